// File: rtl/cnn_pkg.sv
// Shared pixel type, plane geometry and small helpers for the CNN stream stages.
package cnn_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned IN_DIM  = 27;
    localparam int unsigned POOL    = 3;
    localparam int unsigned STRIDE  = 2;
    localparam int unsigned OUT_DIM = (IN_DIM - POOL) / STRIDE + 1;

    // Counter width for input row/col and index width for pooled windows.
    localparam int unsigned CNT_W = $clog2(IN_DIM);
    localparam int unsigned IDX_W = $clog2(OUT_DIM);

    typedef logic signed [DATA_W-1:0] pixel_t;

    // Signed maximum of two pixels.
    function automatic pixel_t pix_max(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

    // Clamp negative pixels to zero.
    function automatic pixel_t relu(input pixel_t x);
        return x[DATA_W-1] ? pixel_t'(0) : x;
    endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Two ping-pong banks of per-window vertical accumulators for the max-pool stage.
module pool_row_buffer
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_max,
    input  logic             wr_sel,
    input  logic [IDX_W-1:0] wr_idx,
    input  pixel_t           wr_data,
    input  logic             rd_sel,
    input  logic [IDX_W-1:0] rd_idx,
    output pixel_t           rd_data_c
);

    pixel_t mem_q [2][OUT_DIM];
    pixel_t mem_d [2][OUT_DIM];

    // Plain write starts a window row; max-write folds in a further row.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_sel][wr_idx] = wr_max ? pix_max(mem_q[wr_sel][wr_idx], wr_data) : wr_data;
        end
    end

    // Accumulator storage; contents are always written before being read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Combinational read of the bank holding the window being completed.
    assign rd_data_c = mem_q[rd_sel][rd_idx];

endmodule

// File: rtl/relu_maxpool_stream.sv
// ReLU followed by 3x3 stride-2 max-pool on a streamed 27x27 plane.
module relu_maxpool_stream
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);

    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] col_q, col_d;
    pixel_t           hmax_q, hmax_d;
    pixel_t           out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             accept;
    logic [CNT_W-1:0] eff_row;
    logic [CNT_W-1:0] eff_col;
    logic             row_last;
    logic             col_last;
    logic             col_even;
    logic             h_done;
    logic [IDX_W-1:0] k_idx;
    pixel_t           pix;
    pixel_t           hval;

    logic             wr_en;
    logic             wr_max;
    logic             wr_sel;
    logic             rd_sel;
    logic             res_load;
    pixel_t           rd_data_c;

    // Stall the input only while a result is waiting on downstream.
    assign in_ready = !out_valid_q || out_ready;

    // Position tracking, horizontal max, bank control and output register next-state.
    always_comb begin
        accept   = in_valid && in_ready;
        eff_row  = in_sof ? '0 : row_q;
        eff_col  = in_sof ? '0 : col_q;
        row_last = (eff_row == CNT_W'(IN_DIM - 1));
        col_last = (eff_col == CNT_W'(IN_DIM - 1));
        col_even = !eff_col[0];
        pix      = relu(pixel_t'(in_data));
        hval     = pix_max(hmax_q, pix);
        // Even columns from 2 up close horizontal window (col/2 - 1).
        h_done   = accept && col_even && (eff_col != '0);
        k_idx    = IDX_W'(eff_col[CNT_W-1:1]) - IDX_W'(1);

        row_d       = row_q;
        col_d       = col_q;
        hmax_d      = hmax_q;
        wr_en       = 1'b0;
        wr_max      = 1'b0;
        wr_sel      = 1'b0;
        rd_sel      = 1'b0;
        res_load    = 1'b0;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : eff_row + CNT_W'(1);
            end else begin
                col_d = eff_col + CNT_W'(1);
                row_d = eff_row;
            end
            // A shared even column both closes one window and opens the next.
            hmax_d = col_even ? pix : hval;
        end

        // Window r lives in bank r[0]; for row R that bank index is R[1].
        if (h_done) begin
            if (eff_row[0]) begin
                wr_en  = 1'b1;
                wr_max = 1'b1;
                wr_sel = eff_row[1];
            end else begin
                if (!row_last) begin
                    wr_en  = 1'b1;
                    wr_sel = eff_row[1];
                end
                if (eff_row != '0) begin
                    rd_sel   = !eff_row[1];
                    res_load = 1'b1;
                end
            end
        end

        if (res_load) begin
            out_valid_d = 1'b1;
            out_data_d  = pix_max(rd_data_c, hval);
            out_last_d  = row_last && col_last;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q       <= '0;
            col_q       <= '0;
            hmax_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            hmax_q      <= hmax_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Vertical accumulator banks.
    pool_row_buffer u_row_buf (
        .clk       (clk),
        .wr_en     (wr_en),
        .wr_max    (wr_max),
        .wr_sel    (wr_sel),
        .wr_idx    (k_idx),
        .wr_data   (hval),
        .rd_sel    (rd_sel),
        .rd_idx    (k_idx),
        .rd_data_c (rd_data_c)
    );

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Directed bench for relu_maxpool_stream with a frame-level window-max model.
module tb_relu_maxpool_stream;

    localparam int N = 27;
    localparam int M = 13;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    relu_maxpool_stream dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    int          img [N][N];
    int          got [M*M];
    int          mr = 0;
    int          mc = 0;
    int          out_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          stalls = 0;
    bit          rdy_rand = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int pix_val(input int kind, input int r, input int c);
        case (kind)
            0: return r * N + c;
            1: return -5;
            2: return (r == 2 && c == 2) ? 1000 : 0;
            3: return (r == 26 && c == 26) ? 1000 : 0;
            default: return 0;
        endcase
    endfunction

    // Frame model: store ReLU'd pixels and take the full 3x3 max when a window's corner arrives.
    task automatic model_accept(input logic [15:0] d, input logic sof);
        int v;
        int m;
        v = int'($signed(d));
        if (v < 0) v = 0;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        if (mr == 0 && mc == 0) out_cnt = 0;
        img[mr][mc] = v;
        if (mr >= 2 && mc >= 2 && (mr % 2) == 0 && (mc % 2) == 0) begin
            m = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    if (img[mr-i][mc-j] > m) m = img[mr-i][mc-j];
            exp_q.push_back('{data: m, last: (mr == N-1 && mc == N-1)});
        end
        mc++;
        if (mc == N) begin
            mc = 0;
            mr++;
            if (mr == N) mr = 0;
        end
    endtask

    // Per-cycle compare against the model, sampled mid-low-phase.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready", int'(in_ready), int'(!out_valid || out_ready));
            if (prev_stall) begin
                check("hold_valid", int'(out_valid), 1);
                check("hold_data", int'(out_data), int'(prev_data));
                check("hold_last", int'(out_last), int'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_output: got data %0d with no pending result", out_data);
                end else begin
                    cur = exp_q.pop_front();
                    check("out_data", int'(out_data), cur.data);
                    check("out_last", int'(out_last), int'(cur.last));
                    if (out_cnt < M*M) got[out_cnt] = int'(out_data);
                    out_cnt++;
                    if (out_last) check("frame_count", out_cnt, M*M);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (prev_stall) stalls++;
            if (in_valid && in_ready) model_accept(in_data, in_sof);
        end
    end

    task automatic tick();
        @(negedge clk);
        out_ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    endtask

    task automatic send_pixels(input int kind, input int n, input bit sof_first);
        int waited;
        for (int i = 0; i < n; i++) begin
            tick();
            in_valid = 1'b1;
            in_data  = 16'(pix_val(kind, i / N, i % N));
            in_sof   = sof_first && (i == 0);
            #1;
            waited = 0;
            while (!in_ready && waited < 1000) begin
                tick();
                #1;
                waited++;
            end
            if (!in_ready) check("input_accept_timeout", 0, 1);
        end
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        tick();
        #1;
        while ((exp_q.size() != 0 || out_valid) && waited < 2000) begin
            tick();
            #1;
            waited++;
        end
        if (exp_q.size() != 0 || out_valid) check("drain_timeout", 0, 1);
    endtask

    task automatic clear_got();
        for (int i = 0; i < M*M; i++) got[i] = -1;
    endtask

    function automatic int got_sum();
        int s;
        s = 0;
        for (int i = 0; i < M*M; i++) s += got[i];
        return s;
    endfunction

    task automatic ramp_literals(input string tag);
        check({tag, "_out00"}, got[0], 56);
        check({tag, "_out11"}, got[14], 112);
        check({tag, "_out1212"}, got[M*M-1], 728);
        check({tag, "_count"}, out_cnt, M*M);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_last", int'(out_last), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_in_ready", int'(in_ready), 1);
        rst = 1'b0;

        // Ramp with continuous flow.
        clear_got();
        send_pixels(0, N*N, 1'b1);
        drain();
        ramp_literals("ramp");

        // All-negative frame pools to zero.
        clear_got();
        send_pixels(1, N*N, 1'b1);
        drain();
        check("neg_sum", got_sum(), 0);
        check("neg_count", out_cnt, M*M);

        // Spike at (2,2) reaches four overlapping windows.
        clear_got();
        send_pixels(2, N*N, 1'b1);
        drain();
        check("spike22_00", got[0], 1000);
        check("spike22_01", got[1], 1000);
        check("spike22_10", got[M], 1000);
        check("spike22_11", got[M+1], 1000);
        check("spike22_sum", got_sum(), 4000);

        // Spike at the last pixel reaches only the last window.
        clear_got();
        send_pixels(3, N*N, 1'b1);
        drain();
        check("spike2626", got[M*M-1], 1000);
        check("spike2626_sum", got_sum(), 1000);

        // Ramp under 30% downstream readiness.
        clear_got();
        stalls   = 0;
        rdy_rand = 1'b1;
        send_pixels(0, N*N, 1'b1);
        drain();
        rdy_rand = 1'b0;
        ramp_literals("bp");
        check("bp_stalled", int'(stalls > 0), 1);

        // Start-of-frame mid-stream resynchronises to a clean frame.
        clear_got();
        send_pixels(0, 100, 1'b1);
        send_pixels(0, N*N, 1'b1);
        drain();
        ramp_literals("sof");

        // Reset mid-frame, then a frame without start-of-frame marker.
        send_pixels(0, 400, 1'b1);
        tick();
        rst = 1'b1;
        exp_q.delete();
        mr      = 0;
        mc      = 0;
        out_cnt = 0;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        clear_got();
        send_pixels(0, N*N, 1'b0);
        drain();
        ramp_literals("rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
